// File: rtl/room_temp_model.sv
// Behavioural thermal plant: integrates the thermostat's heat/cool commands into
// a 5-bit room temperature that moves one degree per step at a mode-dependent rate.
module room_temp_model #(
    parameter int T_INIT      = 20,
    parameter int T_AMBIENT   = 15,
    parameter int HEAT_TICKS  = 4,
    parameter int COOL_TICKS  = 4,
    parameter int DRIFT_TICKS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       heating,
    input  logic       cooling,
    input  logic       load,
    input  logic [4:0] load_value,
    output logic [4:0] temperature,
    output logic       changed,
    output logic       fault
);

    typedef enum logic [1:0] {
        DRIFT = 2'b00,
        COOL  = 2'b01,
        HEAT  = 2'b10,
        HOLD  = 2'b11
    } mode_t;

    localparam int MAX_TICKS_HC = (HEAT_TICKS > COOL_TICKS) ? HEAT_TICKS : COOL_TICKS;
    localparam int MAX_TICKS    = (MAX_TICKS_HC > DRIFT_TICKS) ? MAX_TICKS_HC : DRIFT_TICKS;
    localparam int CW           = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

    localparam logic [CW-1:0] HEAT_LAST  = CW'(HEAT_TICKS - 1);
    localparam logic [CW-1:0] COOL_LAST  = CW'(COOL_TICKS - 1);
    localparam logic [CW-1:0] DRIFT_LAST = CW'(DRIFT_TICKS - 1);
    localparam logic [4:0]    INIT_V     = 5'(T_INIT);
    localparam logic [4:0]    AMBIENT_V  = 5'(T_AMBIENT);

    mode_t         state;
    mode_t         mode;
    logic [CW-1:0] cnt;
    logic [CW-1:0] last;
    logic [4:0]    step_temp;

    // Per-state interval length and the saturating one-degree step.
    always_comb begin
        mode      = mode_t'({heating, cooling});
        last      = '0;
        step_temp = temperature;
        case (state)
            HEAT: begin
                last = HEAT_LAST;
                if (temperature != 5'd31) step_temp = temperature + 5'd1;
            end
            COOL: begin
                last = COOL_LAST;
                if (temperature != 5'd0) step_temp = temperature - 5'd1;
            end
            DRIFT: begin
                last = DRIFT_LAST;
                if (temperature < AMBIENT_V)      step_temp = temperature + 5'd1;
                else if (temperature > AMBIENT_V) step_temp = temperature - 5'd1;
            end
            default: begin
                last      = '0;
                step_temp = temperature;
            end
        endcase
    end

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            temperature <= INIT_V;
            state       <= DRIFT;
            cnt         <= '0;
            changed     <= 1'b0;
            fault       <= 1'b0;
        end else begin
            changed <= 1'b0;
            if (load) begin
                // Load wins over any coincident step and restarts the interval.
                temperature <= load_value;
                cnt         <= '0;
                state       <= mode;
                changed     <= (load_value != temperature);
                if (enable) fault <= heating && cooling;
            end else if (enable) begin
                state <= mode;
                fault <= heating && cooling;
                if (mode != state || state == HOLD) begin
                    cnt <= '0;
                end else if (cnt == last) begin
                    cnt         <= '0;
                    temperature <= step_temp;
                    changed     <= (step_temp != temperature);
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule
